regfile_csr_if: RTL and testbench
=================================

# regfile_csr_if

Register-access front-end for the packed register file (`regfile_s`: `r1.val[31:0]`, `r2.val1[15:0]`, `r2.val2[15:0]`). It sits directly upstream of the register consumers and owns the register storage. It accepts single-beat read/write requests over a valid/ready port and applies byte strobes. It merges a hardware increment source into `r1` and returns one response per request.

## Interface
- `R1_RST`, 32'h0000_0000, reset value of `r1.val`
- `R2_RST`, 32'h0000_0000, reset value of `{r2.val1, r2.val2}`

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  4  byte address
- `req_wdata`  in  32  write data
- `req_wstrb`  in  4  byte enables; bit n covers `[8n+7:8n]`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`
- `rsp_rdata`  out  32  read data; 0 for writes and errors
- `rsp_err`  out  1  address error
- `hw_inc`  in  1  increment `r1.val` by 1 this cycle
- `regs_o`  out  64  current `regfile_s` contents (`r1` in `[63:32]`)

## Operation
Address map, byte addressed, word aligned:
- 0x0: `r1.val`, RW.
- 0x4: `{r2.val1, r2.val2}`, RW. `val1` occupies `[31:16]`.
- 0x8: STATUS, RO except W1C. Bit 0 = `ovf`, sticky, set when `hw_inc` wraps `r1` from 32'hFFFF_FFFF to 0. Bits `[31:1]` read 0.
- 0xC or `req_addr[1:0] != 0`: error. `rsp_err=1`, no state change.

State machine:
- States are IDLE and RESP.
- IDLE: `req_ready=1`, `rsp_valid=0`. On accept, the access is performed at that edge and the response fields are registered. Next state is RESP.
- RESP: `req_ready=0`, `rsp_valid=1`. Response fields are held stable. On `rsp_ready`, go to IDLE. At most one outstanding request.

Access rules:
- Write: only strobed bytes are updated. `wstrb=0` is a legal no-op write with `rsp_err=0`.
- Write to STATUS: `wdata[0]=1` with `wstrb[0]=1` clears `ovf`. All other bits are ignored.
- Read: returns register value as it was before the accepting edge.
- `hw_inc`: honoured in every state, including while `req_ready=0`.

Collisions:
- Same cycle as an accepted write to 0x0: for each byte, the write wins on strobed bytes. Unstrobed bytes take the incremented value's bytes.
- `ovf` sets only if no strobed byte of 0x0 is written that cycle.
- Same cycle as a W1C of `ovf`: set wins.

Reset:
- `req_ready=0` during reset.
- `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- `r1=R1_RST`, `r2=R2_RST`, `ovf=0`, state IDLE.
- Reset mid-RESP drops the pending response without a handshake.

## Timing
- Request-to-response latency is 1 cycle: `rsp_valid` rises the cycle after acceptance.
- Maximum throughput is one request per 2 cycles. It is lower if `rsp_ready` is held low.
- `regs_o` is registered. A write is visible on `regs_o` the cycle after acceptance, together with `rsp_valid`.
- No combinational path from `req_*` to `req_ready`, or from `rsp_ready` to any output.

## Structure
- `regfile_pkg` holds:
  - `reg1_s`, `reg2_s`, `regfile_s`
  - address constants `ADDR_R1=4'h0`, `ADDR_R2=4'h4`, `ADDR_STATUS=4'h8`
  - `STATUS_OVF_BIT=0`
  - the state enum
- One sub-module: `regfile_csr_decode`, combinational. Maps `req_addr` to one-hot select `{r1, r2, status}` plus `err`.

## Test plan
- Reset with `R1_RST=32'h1234_5678`, then read 0x0. Required: `rsp_rdata=32'h1234_5678`, `rsp_err=0`, `rsp_valid` exactly 1 cycle after accept.
- Write 0x4 `wdata=32'hAAAA_5555`, `wstrb=4'b1100`, then read 0x4. Required: read returns 32'hAAAA_0000 and `regs_o[15:0]=16'h0000`.
- Write 0x0 = 32'hFFFF_FFFF, then pulse `hw_inc` once. Required: `r1=0` and STATUS reads 1. W1C write 1 to 0x8. Required: STATUS reads 0.
- Write 0x0 `wdata=32'h0000_00FF`, `wstrb=4'b0001` with `hw_inc=1` and `r1` previously 32'h0000_0100. Required: `r1=32'h0000_01FF`.
- Request to 0xC, then to 0x2. Required: both give `rsp_err=1`, `rsp_rdata=0`, `regs_o` unchanged. Hold `rsp_ready=0` for 5 cycles. Required: `req_ready=0` and the response stays stable throughout.
- Assert `reset` while in RESP. Required: `rsp_valid` drops immediately, all registers return to parameter values, and the next request is accepted normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: register file types, address map and front-end state encoding
package regfile_pkg;
  typedef struct packed {
    logic [31:0] val;
  } reg1_s;
  typedef struct packed {
    logic [15:0] val1;
    logic [15:0] val2;
  } reg2_s;
  typedef struct packed {
    reg1_s r1;
    reg2_s r2;
  } regfile_s;
  typedef enum logic {IDLE, RESP} state_e;
  localparam logic [3:0] ADDR_R1 = 4'h0;
  localparam logic [3:0] ADDR_R2 = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam int STATUS_OVF_BIT = 0;
  localparam int SEL_R1 = 2;
  localparam int SEL_R2 = 1;
  localparam int SEL_STATUS = 0;
  function automatic logic [31:0] strobe_merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] wstrb);
    strobe_merge = old;
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) strobe_merge[8*i+:8] = wdata[8*i+:8];
  endfunction
endpackage

// File: rtl/regfile_csr_decode.sv
// regfile_csr_decode: byte address to one-hot register select, anything unmapped is an error
module regfile_csr_decode
  import regfile_pkg::*;
(
  input  logic [3:0] addr,
  output logic [2:0] sel,
  output logic       err
);
  assign sel = {addr == ADDR_R1, addr == ADDR_R2, addr == ADDR_STATUS};
  assign err = ~|sel;
endmodule

// File: rtl/regfile_csr_if.sv
// regfile_csr_if: valid/ready register front-end owning r1/r2/ovf with a hw increment source
module regfile_csr_if
  import regfile_pkg::*;
#(
  parameter logic [31:0] R1_RST = 32'h0000_0000,
  parameter logic [31:0] R2_RST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        hw_inc,
  output logic [63:0] regs_o
);
  regfile_s regs;
  state_e state;
  logic ovf, accept, wr, err, ovf_set, ovf_clr;
  logic [2:0] sel;
  logic [31:0] r1_inc, rdata;
  regfile_csr_decode u_decode (.addr(req_addr), .sel(sel), .err(err));
  assign accept = req_valid & req_ready;
  assign wr = accept & req_write & ~err;
  assign r1_inc = regs.r1.val + 32'(hw_inc);
  // a software write to any byte of r1 this cycle suppresses the wrap flag
  assign ovf_set = hw_inc & (&regs.r1.val) & ~(wr & sel[SEL_R1] & |req_wstrb);
  assign ovf_clr = wr & sel[SEL_STATUS] & req_wstrb[STATUS_OVF_BIT] & req_wdata[STATUS_OVF_BIT];
  assign rdata = (req_write | err) ? '0 :
                 sel[SEL_R1] ? regs.r1.val :
                 sel[SEL_R2] ? {regs.r2.val1, regs.r2.val2} : {31'b0, ovf};
  assign regs_o = regs;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= regfile_s'({R1_RST, R2_RST});
      ovf <= 1'b0;
    end else begin
      regs.r1.val <= (wr & sel[SEL_R1]) ? strobe_merge(r1_inc, req_wdata, req_wstrb) : r1_inc;
      regs.r2 <= (wr & sel[SEL_R2]) ? reg2_s'(strobe_merge({regs.r2.val1, regs.r2.val2}, req_wdata, req_wstrb)) : regs.r2;
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else if (state == IDLE) begin
      req_ready <= ~accept;
      if (accept) begin
        state <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= rdata;
        rsp_err <= err;
      end
    end else if (rsp_ready) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_csr_if.sv
// tb_regfile_csr_if: directed vector table, reset corner cases and randomized traffic against a reference model
module tb_regfile_csr_if;
  localparam logic [31:0] R1 = 32'h1234_5678;
  localparam logic [31:0] R2 = 32'h0000_0000;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [3:0] req_addr = 0, req_wstrb = 0;
  logic [31:0] req_wdata = 0, rsp_rdata;
  logic rsp_valid, rsp_ready = 0, rsp_err, hw_inc = 0;
  logic [63:0] regs_o;
  int checks = 0, errors = 0;
  logic [31:0] m_r1, m_r2;
  logic m_ovf;

  regfile_csr_if #(.R1_RST(R1), .R2_RST(R2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hw_inc(hw_inc), .regs_o(regs_o));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    m_r1 = R1;
    m_r2 = R2;
    m_ovf = 0;
  endtask

  // one clock edge of the register file as described by its access rules
  task automatic mstep(input logic acc, input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic inc, output logic [31:0] xrd, output logic xerr);
    logic [31:0] n1;
    logic bad, hit1, clr, set;
    bad = !(a == 4'h0 || a == 4'h4 || a == 4'h8);
    xerr = acc && bad;
    xrd = 0;
    if (acc && !w && !bad) xrd = (a == 4'h0) ? m_r1 : (a == 4'h4) ? m_r2 : {31'b0, m_ovf};
    n1 = m_r1 + {31'b0, inc};
    hit1 = 0;
    clr = 0;
    if (acc && w && !bad) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) begin
          if (a == 4'h0) begin n1[8*b+:8] = d[8*b+:8]; hit1 = 1; end
          if (a == 4'h4) m_r2[8*b+:8] = d[8*b+:8];
        end
      clr = (a == 4'h8) && s[0] && d[0];
    end
    set = inc && (m_r1 == 32'hFFFF_FFFF) && !hit1;
    m_ovf = set || (m_ovf && !clr);
    m_r1 = n1;
  endtask

  // incs[k] drives hw_inc in cycle k: 0 = accept, 1..hold = rsp_ready low, hold+1 = handshake
  task automatic txn(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [7:0] incs, input int hold, output logic [31:0] rd, output logic er);
    int n;
    logic acc, xerr, dummy_e;
    logic [31:0] xrd, dummy_r;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    chk("req_ready_wait", req_ready, 1);
    acc = req_ready;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; hw_inc = incs[0];
    @(posedge clock);
    mstep(acc, w, a, d, s, incs[0], xrd, xerr);
    #1;
    req_valid = 0;
    chk("rsp_valid_latency", rsp_valid, 1);
    chk("req_ready_in_resp", req_ready, 0);
    chk("rsp_rdata", rsp_rdata, xrd);
    chk("rsp_err", rsp_err, xerr);
    chk("regs_after_accept", regs_o, {m_r1, m_r2});
    rd = rsp_rdata;
    er = rsp_err;
    for (int k = 1; k <= hold + 1; k++) begin
      @(negedge clock);
      rsp_ready = (k == hold + 1);
      hw_inc = incs[k];
      @(posedge clock);
      mstep(0, 0, 0, 0, 0, incs[k], dummy_r, dummy_e);
      #1;
      if (k <= hold) begin
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_req_ready", req_ready, 0);
        chk("hold_rsp_rdata", rsp_rdata, xrd);
        chk("hold_rsp_err", rsp_err, xerr);
      end else chk("rsp_valid_drop", rsp_valid, 0);
    end
    rsp_ready = 0;
    hw_inc = 0;
  endtask

  typedef struct {
    logic w; logic [3:0] a; logic [31:0] d; logic [3:0] s; logic [7:0] inc; int hold;
    logic [31:0] rd; logic err; logic [63:0] regs;
  } vec_t;
  vec_t tv[19];

  initial begin
    logic [31:0] rd;
    logic er, xe;
    logic [31:0] xr;
    tv[0]  = '{0, 4'h0, 32'h0,         4'h0, 8'h00, 0, 32'h1234_5678, 0, {32'h1234_5678, 32'h0000_0000}};
    tv[1]  = '{1, 4'h4, 32'hAAAA_5555, 4'hC, 8'h00, 0, 32'h0,         0, {32'h1234_5678, 32'hAAAA_0000}};
    tv[2]  = '{0, 4'h4, 32'h0,         4'h0, 8'h00, 0, 32'hAAAA_0000, 0, {32'h1234_5678, 32'hAAAA_0000}};
    tv[3]  = '{1, 4'h0, 32'hFFFF_FFFF, 4'hF, 8'h02, 0, 32'h0,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[4]  = '{0, 4'h8, 32'h0,         4'h0, 8'h00, 0, 32'h1,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[5]  = '{1, 4'h8, 32'h1,         4'h1, 8'h00, 0, 32'h0,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[6]  = '{0, 4'h8, 32'h0,         4'h0, 8'h00, 0, 32'h0,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[7]  = '{1, 4'h0, 32'h0000_0100, 4'hF, 8'h00, 0, 32'h0,         0, {32'h0000_0100, 32'hAAAA_0000}};
    tv[8]  = '{1, 4'h0, 32'h0000_00FF, 4'h1, 8'h01, 0, 32'h0,         0, {32'h0000_01FF, 32'hAAAA_0000}};
    tv[9]  = '{0, 4'hC, 32'h0,         4'h0, 8'h00, 5, 32'h0,         1, {32'h0000_01FF, 32'hAAAA_0000}};
    tv[10] = '{0, 4'h2, 32'h0,         4'h0, 8'h00, 0, 32'h0,         1, {32'h0000_01FF, 32'hAAAA_0000}};
    tv[11] = '{1, 4'h2, 32'hDEAD_BEEF, 4'hF, 8'h00, 0, 32'h0,         1, {32'h0000_01FF, 32'hAAAA_0000}};
    tv[12] = '{1, 4'h4, 32'h1234_4321, 4'h0, 8'h00, 0, 32'h0,         0, {32'h0000_01FF, 32'hAAAA_0000}};
    tv[13] = '{1, 4'h0, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 32'h0,         0, {32'hFFFF_FFFF, 32'hAAAA_0000}};
    tv[14] = '{1, 4'h0, 32'h0,         4'h1, 8'h01, 0, 32'h0,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[15] = '{0, 4'h8, 32'h0,         4'h0, 8'h00, 0, 32'h0,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[16] = '{1, 4'h0, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 32'h0,         0, {32'hFFFF_FFFF, 32'hAAAA_0000}};
    tv[17] = '{1, 4'h8, 32'h1,         4'h1, 8'h01, 0, 32'h0,         0, {32'h0000_0000, 32'hAAAA_0000}};
    tv[18] = '{0, 4'h8, 32'h0,         4'h0, 8'h00, 0, 32'h1,         0, {32'h0000_0000, 32'hAAAA_0000}};
    mreset();
    repeat (3) @(negedge clock);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_regs", regs_o, {R1, R2});
    reset = 0;
    for (int i = 0; i < 19; i++) begin
      txn(tv[i].w, tv[i].a, tv[i].d, tv[i].s, tv[i].inc, tv[i].hold, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("vec%0d_err", i), er, tv[i].err);
      chk($sformatf("vec%0d_regs", i), regs_o, tv[i].regs);
    end
    // reset while a response is pending drops it without a handshake
    @(negedge clock);
    while (!req_ready) @(negedge clock);
    req_valid = 1; req_write = 1; req_addr = 4'h4; req_wdata = 32'h1111_1111; req_wstrb = 4'hF;
    @(posedge clock);
    #1;
    req_valid = 0;
    chk("midresp_rsp_valid", rsp_valid, 1);
    @(negedge clock);
    reset = 1;
    #1;
    chk("midresp_reset_rsp_valid", rsp_valid, 0);
    chk("midresp_reset_req_ready", req_ready, 0);
    chk("midresp_reset_regs", regs_o, {R1, R2});
    mreset();
    @(negedge clock);
    reset = 0;
    txn(0, 4'h4, 0, 0, 0, 0, rd, er);
    chk("post_reset_read_r2", rd, R2);
    chk("post_reset_read_err", er, 0);
    txn(0, 4'h0, 0, 0, 0, 1, rd, er);
    chk("post_reset_read_r1", rd, R1);
    for (int i = 0; i < 60; i++) begin
      logic [3:0] a;
      logic [31:0] d;
      case ($urandom_range(0, 4))
        0: a = 4'h0;
        1: a = 4'h4;
        2: a = 4'h8;
        3: a = 4'hC;
        default: a = 4'($urandom);
      endcase
      d = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
      txn(1'($urandom), a, d, 4'($urandom), 8'($urandom), $urandom_range(0, 3), rd, er);
      mstep(0, 0, 0, 0, 0, 0, xr, xe);
      chk($sformatf("rand%0d_regs", i), regs_o, {m_r1, m_r2});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
